// File: rtl/known_ch_table.sv
`default_nettype none
// ============================================================================
// Module  : known_ch_table
// Collects cluster-head adverts until idle timeout, then picks one entry:
// fewest hops, then highest Q, then lowest ID.
// Option  : KCH_DUP_UPDATE_EN -- a repeated ID updates its stored entry in place.
// Revision: 1.0
// ============================================================================
module known_ch_table #(
   parameter int WORD_WIDTH     = 16,
   parameter int NUM_ENTRIES    = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en_KCH,
   input  logic                              HB_reset,
   input  logic [WORD_WIDTH-1:0]             HB_CHlimit,
   input  logic [WORD_WIDTH-1:0]             fCH_ID,
   input  logic [WORD_WIDTH-1:0]             fCH_Hops,
   input  logic [WORD_WIDTH-1:0]             fCH_QValue,
   output logic [WORD_WIDTH-1:0]             chosenCH,
   output logic [WORD_WIDTH-1:0]             hopsfromCH,
   output logic                              ch_valid,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]  ch_count,
   output logic                              busy
);

   localparam int CW = $clog2(NUM_ENTRIES + 1);
   localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam logic [WORD_WIDTH-1:0] C_ONES    = '1;
   localparam logic [WORD_WIDTH-1:0] C_TIMEOUT = WORD_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]         C_DEPTH   = CW'(NUM_ENTRIES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_EVAL    = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic [WORD_WIDTH-1:0]  timer_q, timer_d;
   logic [IW-1:0]          scan_q, scan_d;
   logic [WORD_WIDTH-1:0]  best_hops_q, best_hops_d;
   logic [WORD_WIDTH-1:0]  best_qv_q, best_qv_d;
   logic [WORD_WIDTH-1:0]  best_id_q, best_id_d;
   logic [WORD_WIDTH-1:0]  chosen_q, chosen_d;
   logic [WORD_WIDTH-1:0]  hops_out_q, hops_out_d;

   logic [WORD_WIDTH-1:0]  tbl_id_q   [NUM_ENTRIES];
   logic [WORD_WIDTH-1:0]  tbl_hops_q [NUM_ENTRIES];
   logic [WORD_WIDTH-1:0]  tbl_qv_q   [NUM_ENTRIES];

   logic                   wr_en;
   logic                   wr_new;
   logic [IW-1:0]          wr_idx;
   logic [CW-1:0]          limit;
   logic                   dup_hit;
   logic [IW-1:0]          dup_idx;
   logic [WORD_WIDTH-1:0]  cur_id, cur_hops, cur_qv;
   logic                   replace;
   logic                   last_scan;

   // Zero, or anything above the table depth, means "use the whole table".
   always_comb begin
      if ((HB_CHlimit == '0) || (HB_CHlimit > WORD_WIDTH'(NUM_ENTRIES))) begin
         limit = C_DEPTH;
      end else begin
         limit = CW'(HB_CHlimit);
      end
   end

`ifdef KCH_DUP_UPDATE_EN
   always_comb begin
      dup_hit = 1'b0;
      dup_idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!dup_hit && (CW'(i) < count_q) && (tbl_id_q[i] == fCH_ID)) begin
            dup_hit = 1'b1;
            dup_idx = IW'(i);
         end
      end
   end
`else
   assign dup_hit = 1'b0;
   assign dup_idx = '0;
`endif

   assign cur_id    = tbl_id_q[scan_q];
   assign cur_hops  = tbl_hops_q[scan_q];
   assign cur_qv    = tbl_qv_q[scan_q];
   assign last_scan = ((CW'(scan_q) + CW'(1)) >= count_q);

   assign replace = (cur_hops < best_hops_q) ||
                    ((cur_hops == best_hops_q) && (cur_qv > best_qv_q)) ||
                    ((cur_hops == best_hops_q) && (cur_qv == best_qv_q) && (cur_id < best_id_q));

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      timer_d     = timer_q;
      scan_d      = scan_q;
      best_hops_d = best_hops_q;
      best_qv_d   = best_qv_q;
      best_id_d   = best_id_q;
      chosen_d    = chosen_q;
      hops_out_d  = hops_out_q;
      wr_en       = 1'b0;
      wr_new      = 1'b0;
      wr_idx      = count_q[IW-1:0];

      case (state_q)
         S_IDLE: begin
            if (en_KCH) begin
               wr_en   = 1'b1;
               wr_new  = 1'b1;
               wr_idx  = '0;
               count_d = CW'(1);
               timer_d = C_TIMEOUT;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (en_KCH && dup_hit) begin
               wr_en   = 1'b1;
               wr_idx  = dup_idx;
               timer_d = C_TIMEOUT;
            end else if (en_KCH && (count_q < limit)) begin
               wr_en   = 1'b1;
               wr_new  = 1'b1;
               count_d = count_q + CW'(1);
               timer_d = C_TIMEOUT;
            end else if (timer_q <= WORD_WIDTH'(1)) begin
               // Dropped adverts fall through here too: they never reload the timer.
               timer_d     = '0;
               scan_d      = '0;
               best_hops_d = C_ONES;
               best_qv_d   = '0;
               best_id_d   = C_ONES;
               state_d     = S_EVAL;
            end else begin
               timer_d = timer_q - WORD_WIDTH'(1);
            end
         end
         S_EVAL: begin
            if (replace) begin
               best_hops_d = cur_hops;
               best_qv_d   = cur_qv;
               best_id_d   = cur_id;
            end
            // Outputs load with the final comparison folded in so they line up with ch_valid.
            if (last_scan) begin
               chosen_d   = replace ? cur_id   : best_id_q;
               hops_out_d = replace ? cur_hops : best_hops_q;
               state_d    = S_DONE;
            end else begin
               scan_d = scan_q + IW'(1);
            end
         end
         S_DONE: begin
            count_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (HB_reset) begin
         state_d    = S_IDLE;
         count_d    = '0;
         timer_d    = '0;
         chosen_d   = chosen_q;
         hops_out_d = hops_out_q;
         wr_en      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         timer_q     <= '0;
         scan_q      <= '0;
         best_hops_q <= C_ONES;
         best_qv_q   <= '0;
         best_id_q   <= C_ONES;
         chosen_q    <= C_ONES;
         hops_out_q  <= C_ONES;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         timer_q     <= timer_d;
         scan_q      <= scan_d;
         best_hops_q <= best_hops_d;
         best_qv_q   <= best_qv_d;
         best_id_q   <= best_id_d;
         chosen_q    <= chosen_d;
         hops_out_q  <= hops_out_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         if (wr_new) begin
            tbl_id_q[wr_idx] <= fCH_ID;
         end
         tbl_hops_q[wr_idx] <= fCH_Hops;
         tbl_qv_q[wr_idx]   <= fCH_QValue;
      end
   end

   assign chosenCH   = chosen_q;
   assign hopsfromCH = hops_out_q;
   assign ch_valid   = (state_q == S_DONE);
   assign ch_count   = count_q;
   assign busy       = (state_q == S_EVAL) || (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_known_ch_table.sv
`default_nettype none
// ============================================================================
// Module  : tb_known_ch_table
// Directed and randomized checks of known_ch_table against a keyed-minimum model.
// Revision: 1.0
// ============================================================================
module tb_known_ch_table;

   localparam int W   = 16;
   localparam int N   = 4;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en_KCH = 1'b0;
   logic          HB_reset = 1'b0;
   logic [W-1:0]  lim = '0;
   logic [W-1:0]  fCH_ID = '0;
   logic [W-1:0]  fCH_Hops = '0;
   logic [W-1:0]  fCH_QValue = '0;
   logic [W-1:0]  chosenCH;
   logic [W-1:0]  hopsfromCH;
   logic          ch_valid;
   logic [2:0]    ch_count;
   logic          busy;

   known_ch_table #(.WORD_WIDTH(W), .NUM_ENTRIES(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .en_KCH     (en_KCH),
      .HB_reset   (HB_reset),
      .HB_CHlimit (lim),
      .fCH_ID     (fCH_ID),
      .fCH_Hops   (fCH_Hops),
      .fCH_QValue (fCH_QValue),
      .chosenCH   (chosenCH),
      .hopsfromCH (hopsfromCH),
      .ch_valid   (ch_valid),
      .ch_count   (ch_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {int id; int h; int q;} ent_t;

   ent_t          mq[$];
   int            cyc = 0;
   int            last_acc = 0;
   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  exp_ch = '1;
   logic [W-1:0]  exp_hops = '1;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input int id, input int h, input int q);
      bit acc;
      int L;
      en_KCH     = 1'b1;
      fCH_ID     = W'(id);
      fCH_Hops   = W'(h);
      fCH_QValue = W'(q);
      tick();
      en_KCH = 1'b0;
      L   = ((lim == '0) || (lim > W'(N))) ? N : int'(lim);
      acc = 1'b0;
`ifdef KCH_DUP_UPDATE_EN
      foreach (mq[i]) begin
         if (!acc && (mq[i].id == id)) begin
            mq[i].h = h;
            mq[i].q = q;
            acc     = 1'b1;
         end
      end
`endif
      if (!acc && (mq.size() < L)) begin
         mq.push_back('{id, h, q});
         acc = 1'b1;
      end
      if (acc) last_acc = cyc;
   endtask

   // Winner is the smallest {hops, ~Q, ID} key; the empty-table key is all ones.
   task automatic finish_round(input string tag, input bit inj);
      int          expc;
      logic [47:0] key;
      logic [47:0] k;
      bit          injd;
      expc = last_acc + TMO + mq.size();
      key  = '1;
      foreach (mq[i]) begin
         k = {W'(mq[i].h), ~W'(mq[i].q), W'(mq[i].id)};
         if (k < key) key = k;
      end
      exp_ch   = key[15:0];
      exp_hops = key[47:32];
      injd     = 1'b0;
      while (!ch_valid && (cyc < expc + 6)) begin
         if (inj && busy && !injd) begin
            en_KCH = 1'b1; fCH_ID = '0; fCH_Hops = '0; fCH_QValue = W'(255);
            injd = 1'b1;
            tick();
            en_KCH = 1'b0;
         end else begin
            tick();
         end
      end
      chk({tag, "_latency"}, 48'(cyc), 48'(expc));
      chk({tag, "_valid"}, 48'(ch_valid), 48'(1));
      chk({tag, "_chosenCH"}, 48'(chosenCH), 48'(exp_ch));
      chk({tag, "_hops"}, 48'(hopsfromCH), 48'(exp_hops));
      if (inj) begin
         en_KCH = 1'b1; fCH_ID = '0; fCH_Hops = '0; fCH_QValue = W'(255);
      end
      tick();
      en_KCH = 1'b0;
      chk({tag, "_pulse"}, 48'(ch_valid), 48'(0));
      chk({tag, "_cleared"}, 48'(ch_count), 48'(0));
      chk({tag, "_idle"}, 48'(busy), 48'(0));
      mq.delete();
   endtask

   task automatic watch_quiet(input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ch_valid) seen++;
      end
      chk({tag, "_no_valid"}, 48'(seen), 48'(0));
      chk({tag, "_count"}, 48'(ch_count), 48'(0));
      chk({tag, "_retained"}, 48'(chosenCH), 48'(exp_ch));
      mq.delete();
   endtask

   initial begin
      int n;
      int gap;
      int waitc;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_chosen", 48'(chosenCH), 48'(16'hFFFF));
      chk("rst_hops", 48'(hopsfromCH), 48'(16'hFFFF));
      chk("rst_valid", 48'(ch_valid), 48'(0));
      chk("rst_count", 48'(ch_count), 48'(0));
      chk("rst_busy", 48'(busy), 48'(0));

      // Heartbeat clear during collection abandons the round
      send(8, 3, 0);
      repeat (3) tick();
      HB_reset = 1'b1;
      tick();
      HB_reset = 1'b0;
      watch_quiet("hb_collect");
      chk("hb_collect_allones", 48'(chosenCH), 48'(16'hFFFF));

      // Equal hops and Q: lowest ID wins
      send(5, 3, 10); send(7, 2, 4); send(3, 2, 4);
      chk("three_count", 48'(ch_count), 48'(3));
      finish_round("three", 1'b0);
      chk("three_id_const", 48'(chosenCH), 48'(3));

      // Q outranks ID at equal hops
      send(9, 1, 5); send(2, 1, 9);
      finish_round("qbeats", 1'b0);
      chk("qbeats_id_const", 48'(chosenCH), 48'(2));

      // Limit of two drops the third advert without reloading the timer
      lim = W'(2);
      send(4, 5, 1); send(6, 5, 1); send(1, 1, 99);
      chk("limit_count", 48'(ch_count), 48'(2));
      finish_round("limit", 1'b0);
      chk("limit_id_const", 48'(chosenCH), 48'(4));
      lim = '0;

      // Repeated ID: in-place update or separate slot depending on build
      send(5, 4, 1); send(6, 3, 1); send(5, 1, 1);
      chk("dup_count", 48'(ch_count), 48'(mq.size()));
      finish_round("dup", 1'b0);
      chk("dup_id_const", 48'(chosenCH), 48'(5));

      // Adverts while busy are ignored; the next round starts empty
      send(10, 2, 2);
      finish_round("busy_inj", 1'b1);
      send(20, 5, 5);
      chk("after_inj_count", 48'(ch_count), 48'(1));
      finish_round("after_inj", 1'b0);

      // Heartbeat clear mid-evaluation, with a coincident advert
      send(11, 2, 3); send(12, 1, 3); send(13, 1, 4);
      waitc = 0;
      while (!busy && (waitc < 40)) begin
         tick();
         waitc++;
      end
      chk("hb_eval_reached", 48'(busy), 48'(1));
      HB_reset = 1'b1; en_KCH = 1'b1; fCH_ID = W'(1); fCH_Hops = '0; fCH_QValue = '0;
      tick();
      HB_reset = 1'b0; en_KCH = 1'b0;
      chk("hb_eval_busy", 48'(busy), 48'(0));
      watch_quiet("hb_eval");

      // Randomized rounds
      for (int r = 0; r < 8; r++) begin
         lim = W'($urandom_range(0, 5));
         n   = $urandom_range(1, 4);
         for (int e = 0; e < n; e++) begin
            send($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
            gap = $urandom_range(0, 1);
            repeat (gap) tick();
         end
         chk($sformatf("rnd%0d_count", r), 48'(ch_count), 48'(mq.size()));
         finish_round($sformatf("rnd%0d", r), r[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
